std_ram_write_arbiter: RTL

STD_RAM_WRITE_ARBITER -- requirements
Module: std_ram_write_arbiter

---
 rtl/std_ram_write_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/std_ram_write_arbiter.sv
// std_ram_write_arbiter: round-robin write arbiter in front of a single RAM write port,
// with an optional whole-RAM clear sweep (enabled by STD_RAM_WRITE_ARBITER_CLEAR_EN).
// Ports:
//   i_clk, i_rst              clock; asynchronous active-low reset
//   i_valid/i_adr/i_data      per-requester write request, address and data
//   o_ready                   one-hot grant, zero latency
//   i_clr_start               start a clear sweep (ignored unless CLEAR_EN is defined)
//   o_mea/o_wea/o_adra/o_da   RAM port-A enable, write-enable, address, data
//   o_busy, o_clr_done        sweep in progress; one-cycle pulse when a sweep completes
module std_ram_write_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int WORD_SIZE = 16,
    parameter int ADDRESS_WIDTH = (WORD_SIZE < 2) ? 1 : $clog2(WORD_SIZE),
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [REQUESTERS-1:0]                   i_valid,
    input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0] i_adr,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]    i_data,
    output logic [REQUESTERS-1:0]                   o_ready,
    input  logic                                    i_clr_start,
    output logic                                    o_mea,
    output logic                                    o_wea,
    output logic [ADDRESS_WIDTH-1:0]                o_adra,
    output logic [DATA_WIDTH-1:0]                   o_da,
    output logic                                    o_busy,
    output logic                                    o_clr_done
);
    localparam int PW = $clog2(REQUESTERS);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    logic [PW-1:0] win;
    logic          found;

    // First asserted valid at or above the pointer, wrapping to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            cand = PW'((int'(ptr_q) + i) % REQUESTERS);
            if (!found && i_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef STD_RAM_WRITE_ARBITER_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(WORD_SIZE - 1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic                     done_q, done_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ptr_d   = ptr_q;
        o_ready = '0;
        o_mea   = 1'b0;
        o_wea   = 1'b0;
        o_adra  = '0;
        o_da    = '0;
        if (state_q == CLEAR) begin
            o_mea  = 1'b1;
            o_wea  = 1'b1;
            o_adra = cnt_q;
            o_da   = CLEAR_VALUE;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (found) begin
                o_ready[win] = 1'b1;
                o_mea        = 1'b1;
                o_wea        = 1'b1;
                o_adra       = i_adr[win];
                o_da         = i_data[win];
                ptr_d        = (win == PW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
            end
            // The pending write above is still granted in the start cycle.
            if (i_clr_start) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end
    end

    assign o_busy     = (state_q == CLEAR);
    assign o_clr_done = done_q;
`else
    logic unused_clr_start;
    assign unused_clr_start = i_clr_start;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        o_ready = '0;
        o_mea   = 1'b0;
        o_wea   = 1'b0;
        o_adra  = '0;
        o_da    = '0;
        if (found) begin
            o_ready[win] = 1'b1;
            o_mea        = 1'b1;
            o_wea        = 1'b1;
            o_adra       = i_adr[win];
            o_da         = i_data[win];
            ptr_d        = (win == PW'(REQUESTERS - 1)) ? '0 : win + 1'b1;
        end
    end

    assign o_busy     = 1'b0;
    assign o_clr_done = 1'b0;
`endif
endmodule
